// File: rtl/gate_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : gate_unit_seq
// Description : Bitwise gate unit with a one-shot manual mode and a paced
//               scan mode that walks opcodes 0..6 with DIV-cycle beat spacing.
// Revision    : 1.0 - initial release
// ============================================================================
module gate_unit_seq #(
    parameter int WIDTH = 8,
    parameter int DIV   = 50_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] y,
    output logic [2:0]       op_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int CW = $clog2(DIV) + 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);
    localparam bit SINGLE_CYCLE_BEAT = (DIV == 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_HOLD      = 2'd1;
    localparam logic [1:0] S_SCAN_OUT  = 2'd2;
    localparam logic [1:0] S_SCAN_WAIT = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic             accept;
    logic             consume;
    logic             last_beat;
    logic             wait_done;
    logic [2:0]       req_op;
    logic [2:0]       next_op;

    function automatic logic [WIDTH-1:0] gate_f(input logic [2:0] f_op,
                                                input logic [WIDTH-1:0] fa,
                                                input logic [WIDTH-1:0] fb);
        case (f_op)
            3'd0:    gate_f = fa & fb;
            3'd1:    gate_f = fa | fb;
            3'd2:    gate_f = ~fa;
            3'd3:    gate_f = ~(fa & fb);
            3'd4:    gate_f = ~(fa | fb);
            3'd5:    gate_f = fa ^ fb;
            3'd6:    gate_f = ~(fa ^ fb);
            default: gate_f = fa;
        endcase
    endfunction

    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;
    assign last_beat = (op_out == 3'd6);
    assign wait_done = (cnt <= CW'(1));
    assign req_op    = mode ? 3'd0 : op;
    assign next_op   = op_out + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) next_state = mode ? S_SCAN_OUT : S_HOLD;
            end
            S_HOLD: begin
                if (consume) begin
                    if (accept) next_state = mode ? S_SCAN_OUT : S_HOLD;
                    else        next_state = S_IDLE;
                end
            end
            S_SCAN_OUT: begin
                if (consume) begin
                    if (last_beat)              next_state = S_IDLE;
                    else if (SINGLE_CYCLE_BEAT) next_state = S_SCAN_OUT;
                    else                        next_state = S_SCAN_WAIT;
                end
            end
            default: begin
                if (wait_done) next_state = S_SCAN_OUT;
            end
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b1;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_HOLD:  in_ready = out_ready;
            default: ;
        endcase
    end

    // Operands are captured so a scan keeps using the accepted values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            y         <= '0;
            op_out    <= 3'd0;
            out_valid <= 1'b0;
            cnt       <= '0;
        end else if (accept) begin
            a_q       <= a;
            b_q       <= b;
            y         <= gate_f(req_op, a, b);
            op_out    <= req_op;
            out_valid <= 1'b1;
            cnt       <= '0;
        end else begin
            case (state)
                S_HOLD: begin
                    if (consume) out_valid <= 1'b0;
                end
                S_SCAN_OUT: begin
                    if (consume) begin
                        if (last_beat) begin
                            out_valid <= 1'b0;
                        end else if (SINGLE_CYCLE_BEAT) begin
                            y      <= gate_f(next_op, a_q, b_q);
                            op_out <= next_op;
                        end else begin
                            out_valid <= 1'b0;
                            cnt       <= CNT_LOAD;
                        end
                    end
                end
                S_SCAN_WAIT: begin
                    if (wait_done) begin
                        cnt       <= '0;
                        y         <= gate_f(next_op, a_q, b_q);
                        op_out    <= next_op;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gate_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_gate_unit_seq
// Description : Directed self-checking bench for gate_unit_seq (WIDTH=4, DIV=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_unit_seq;

    localparam int WIDTH = 4;
    localparam int DIV   = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] y;
    logic [2:0]       op_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [WIDTH-1:0] scan_exp [7] = '{4'b1000, 4'b1110, 4'b0011, 4'b0111,
                                       4'b0001, 4'b0110, 4'b1001};

    gate_unit_seq #(.WIDTH(WIDTH), .DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .op        (op),
        .mode      (mode),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .y         (y),
        .op_out    (op_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, got running expected finished");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_manual();
        a = 4'b1100; b = 4'b1010; op = 3'd5; mode = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL idle_in_ready: got %b expected 1", in_ready);
        else pass_cnt++;
        tick();
        op = 3'd7;
        total_cnt++;
        if (y !== 4'b0110 || op_out !== 3'd5 || out_valid !== 1'b1)
            $display("FAIL manual_xor: got y=%b op=%0d v=%b expected y=0110 op=5 v=1", y, op_out, out_valid);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (y !== 4'b1100 || op_out !== 3'd7 || out_valid !== 1'b1)
            $display("FAIL manual_pass_b2b: got y=%b op=%0d v=%b expected y=1100 op=7 v=1", y, op_out, out_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL manual_idle: got v=%b busy=%b expected v=0 busy=0", out_valid, busy);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        a = 4'b1100; b = 4'b1010; op = 3'd1; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b1 || busy !== 1'b1)
            $display("FAIL reset_preload: got v=%b busy=%b expected v=1 busy=1", out_valid, busy);
        else pass_cnt++;
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || y !== 4'b0000 || op_out !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL async_reset: got v=%b y=%b op=%0d busy=%b rdy=%b expected v=0 y=0000 op=0 busy=0 rdy=1",
                     out_valid, y, op_out, busy, in_ready);
        else pass_cnt++;
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_backpressure();
        a = 4'b1100; b = 4'b1010; op = 3'd1; mode = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        op = 3'd3;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (y !== 4'b1110 || op_out !== 3'd1 || out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL bp_hold[%0d]: got y=%b op=%0d v=%b rdy=%b expected y=1110 op=1 v=1 rdy=0",
                         i, y, op_out, out_valid, in_ready);
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_follow: got %b expected 1", in_ready);
        else pass_cnt++;
        tick();
        in_valid = 1'b0;
        total_cnt++;
        if (y !== 4'b0111 || op_out !== 3'd3 || out_valid !== 1'b1)
            $display("FAIL bp_reload: got y=%b op=%0d v=%b expected y=0111 op=3 v=1", y, op_out, out_valid);
        else pass_cnt++;
        tick();
    endtask

    task automatic test_scan();
        a = 4'b1100; b = 4'b1010; op = 3'd4; mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; a = 4'b0000; b = 4'b0000;
        for (int k = 0; k < 7; k++) begin
            total_cnt++;
            if (out_valid !== 1'b1 || y !== scan_exp[k] || op_out !== 3'(k) || in_ready !== 1'b0)
                $display("FAIL scan_beat[%0d]: got v=%b y=%b op=%0d rdy=%b expected v=1 y=%b op=%0d rdy=0",
                         k, out_valid, y, op_out, in_ready, scan_exp[k], k);
            else pass_cnt++;
            if (k < 6) begin
                for (int g = 0; g < DIV - 1; g++) begin
                    tick();
                    total_cnt++;
                    if (out_valid !== 1'b0 || busy !== 1'b1)
                        $display("FAIL scan_gap[%0d.%0d]: got v=%b busy=%b expected v=0 busy=1", k, g, out_valid, busy);
                    else pass_cnt++;
                end
            end
            tick();
        end
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL scan_end: got v=%b busy=%b rdy=%b expected v=0 busy=0 rdy=1", out_valid, busy, in_ready);
        else pass_cnt++;
        mode = 1'b0;
    endtask

    task automatic test_scan_stall();
        int budget;
        a = 4'b1100; b = 4'b1010; mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (DIV) tick();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if (y !== 4'b1110 || op_out !== 3'd1 || out_valid !== 1'b1)
                $display("FAIL stall_hold[%0d]: got y=%b op=%0d v=%b expected y=1110 op=1 v=1", i, y, op_out, out_valid);
            else pass_cnt++;
            tick();
        end
        out_ready = 1'b1;
        tick();
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL stall_gap: got v=%b expected 0", out_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1 || y !== 4'b0011 || op_out !== 3'd2)
            $display("FAIL stall_next: got v=%b y=%b op=%0d expected v=1 y=0011 op=2", out_valid, y, op_out);
        else pass_cnt++;
        budget = 0;
        while (busy === 1'b1 && budget < 40) begin
            tick();
            budget++;
        end
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL stall_drain: got busy=%b expected 0", busy);
        else pass_cnt++;
        mode = 1'b0;
    endtask

    task automatic test_scan_reset();
        logic seen_valid;
        a = 4'b1100; b = 4'b1010; mode = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2 * DIV + 1) tick();
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || op_out !== 3'd2)
            $display("FAIL sreset_wait: got v=%b busy=%b op=%0d expected v=0 busy=1 op=2", out_valid, busy, op_out);
        else pass_cnt++;
        #3 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL sreset_async: got v=%b busy=%b expected v=0 busy=0", out_valid, busy);
        else pass_cnt++;
        #2 rst_n = 1'b1;
        mode = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen_valid = 1'b1;
        end
        total_cnt++;
        if (seen_valid !== 1'b0)
            $display("FAIL sreset_quiet: got stray activity=%b expected 0", seen_valid);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0; a = '0; b = '0; op = 3'd0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #3;
        total_cnt++;
        if (out_valid !== 1'b0 || y !== 4'b0000 || op_out !== 3'd0 || busy !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL power_on_reset: got v=%b y=%b op=%0d busy=%b rdy=%b expected v=0 y=0000 op=0 busy=0 rdy=1",
                     out_valid, y, op_out, busy, in_ready);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
        test_manual();
        test_reset();
        test_backpressure();
        test_scan();
        test_scan_stall();
        test_scan_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
